ipm_req_arbiter: RTL and testbench
==================================

Name: ipm_req_arbiter

Overview:
Shares the single multi-cycle IPM (inner-product masking) multiplier between NumReq requesters, e.g. the core EX stage and a masking accelerator port. Arbitrates, latches operands, sequences the IPM unit's enable/select, watchdogs its completion and returns the result to the owner over a valid/ready channel. Sits beside the execute block, between the requesters and the IPM unit's ipm_en/ipm_sel/valid interface.

Parameters:
NumReq, 2, number of requesters (2..8)
TimeoutCycles, 64, max cycles from IPM enable to IPM valid before an error response (>=2)
FixedPrio, 1'b1, 1 = lowest index always wins; 0 = round-robin

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
req_valid_i  in  NumReq  request pending, one bit per requester
req_ready_o  out  NumReq  request accepted (one-hot or zero)
req_op_i  in  NumReq x ibex_pkg::ipm_op_e  operator per requester
req_a_i  in  NumReq x 32  operand A per requester
req_b_i  in  NumReq x 32  operand B per requester
rsp_valid_o  out  NumReq  response valid to owner (one-hot or zero)
rsp_ready_i  in  NumReq  owner accepts response
rsp_result_o  out  32  shared result bus, meaningful only with rsp_valid_o
rsp_err_o  out  1  response is a timeout error
ipm_en_o  out  1  single-cycle start pulse to IPM unit
ipm_sel_o  out  1  IPM unit selected/owned
ipm_operator_o  out  ibex_pkg::ipm_op_e  latched operator
ipm_operand_a_o  out  32  latched operand A
ipm_operand_b_o  out  32  latched operand B
ipm_valid_i  in  1  IPM result valid
ipm_result_i  in  32  IPM result
busy_o  out  1  state != IDLE
owner_o  out  $clog2(NumReq)  index of current owner
timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (rst_i high at clock edge): state IDLE, all outputs 0, rr pointer 0, counter 0, operand/result registers 0. Reset mid-operation aborts with no response; ipm_sel_o low in the next cycle.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: winner chosen combinationally among req_valid_i (FixedPrio: lowest index; else first set bit at or after rr pointer, wrapping). req_ready_o[winner]=1 only in IDLE. On valid&ready: latch op/a/b, owner_o=winner -> ISSUE. No request: stay.
- ISSUE (1 cycle): ipm_en_o=1, ipm_sel_o=1, counter cleared. ipm_valid_i high here -> capture result -> RESP; else -> WAIT.
- WAIT: ipm_en_o=0, ipm_sel_o=1, counter increments. ipm_valid_i -> capture ipm_result_i, rsp_err_o next=0 -> RESP. Counter reaching TimeoutCycles-1 without valid -> result 0, err 1, timeout_o pulse -> RESP. Valid and expiry in the same cycle: valid wins, no error.
- RESP: ipm_sel_o=0; rsp_valid_o[owner]=1, result/err held stable until rsp_ready_i[owner]; then -> IDLE, rr pointer = owner+1 mod NumReq. rsp_ready_i of non-owners ignored.
- Operand outputs stable from ISSUE until leaving WAIT. ipm_valid_i in IDLE/RESP ignored.
- Latency: accept at cycle 0, ipm_en_o cycle 1, earliest rsp_valid_o cycle 2 (single-cycle unit); no back-to-back issue (min 3 cycles/op).
- req_ready_o never high outside IDLE; at most one bit set.

Decomposition:
- ibex_pkg: ipm_arb_state_e {IDLE, ISSUE, WAIT, RESP}; reuse ipm_op_e.
- Sub-module ipm_rr_arbiter: combinational winner/any-valid from req vector, pointer and FixedPrio; pointer register stays in parent.

Test Plan:
- Single req0 op, unit valid 3 cycles after ipm_en_o, result 0x1234_5678 -> ipm_en_o one cycle, ipm_sel_o high ISSUE..WAIT, rsp_valid_o=01, result 0x12345678, err 0.
- FixedPrio=0, both requesters valid continuously, 4 ops -> grant order 0,1,0,1; FixedPrio=1 -> 0,0,0,0 (req1 starved).
- Unit never asserts valid, TimeoutCycles=8 -> timeout_o pulse 8 cycles after ipm_en_o, rsp_err_o=1, result 0, returns IDLE after rsp_ready_i.
- Single-cycle unit (ipm_valid_i in ISSUE) -> rsp_valid_o in cycle 2; rsp_ready_i held low 5 cycles -> result stable, req_ready_o stays 0, new request waits.
- rst_i asserted during WAIT -> next cycle all outputs 0, busy_o 0; subsequent request served normally from rr pointer 0.
- ipm_valid_i in same cycle as watchdog expiry -> normal response, err 0, no timeout_o.

Source files
------------

// File: rtl/ipm_req_arbiter_pkg.sv
// Types shared by the IPM request arbiter and its users.
package ipm_req_arbiter_pkg;

    typedef enum logic [1:0] {
        IPM_OP_MUL    = 2'd0,
        IPM_OP_MASK   = 2'd1,
        IPM_OP_UNMASK = 2'd2,
        IPM_OP_SQR    = 2'd3
    } ipm_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } ipm_arb_state_e;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ipm_rr_arbiter.sv
// Combinational winner select: lowest index, or first set bit at/after ptr_i with wrap.
module ipm_rr_arbiter #(
    parameter int NumReq    = 2,
    parameter bit FixedPrio = 1'b1
) (
    input  logic [NumReq-1:0]         req_i,
    input  logic [$clog2(NumReq)-1:0] ptr_i,
    output logic [$clog2(NumReq)-1:0] gnt_idx_o,
    output logic                      any_o
);
    localparam int IdxW = $clog2(NumReq);

    logic [IdxW-1:0]   start;
    logic [NumReq-1:0] rot;
    int                win;

    assign start = FixedPrio ? '0 : ptr_i;
    // Rotate so the highest-priority requester lands at bit 0.
    assign rot   = NumReq'({req_i, req_i} >> start);
    assign any_o = |req_i;

    always_comb begin
        win = 0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (rot[i]) win = i;
        end
        win = win + int'(start);
        if (win >= NumReq) win = win - NumReq;
        gnt_idx_o = IdxW'(win);
    end

endmodule

// File: rtl/ipm_req_arbiter.sv
// Shares one multi-cycle IPM unit between NumReq requesters: arbitrate, issue,
// watchdog the unit and return the result to the owner over valid/ready.
module ipm_req_arbiter
    import ipm_req_arbiter_pkg::*;
#(
    parameter int NumReq        = 2,
    parameter int TimeoutCycles = 64,
    parameter bit FixedPrio     = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumReq-1:0]         req_valid_i,
    output logic [NumReq-1:0]         req_ready_o,
    input  ipm_op_e [NumReq-1:0]      req_op_i,
    input  logic [NumReq-1:0][31:0]   req_a_i,
    input  logic [NumReq-1:0][31:0]   req_b_i,
    output logic [NumReq-1:0]         rsp_valid_o,
    input  logic [NumReq-1:0]         rsp_ready_i,
    output logic [31:0]               rsp_result_o,
    output logic                      rsp_err_o,
    output logic                      ipm_en_o,
    output logic                      ipm_sel_o,
    output ipm_op_e                   ipm_operator_o,
    output logic [31:0]               ipm_operand_a_o,
    output logic [31:0]               ipm_operand_b_o,
    input  logic                      ipm_valid_i,
    input  logic [31:0]               ipm_result_i,
    output logic                      busy_o,
    output logic [$clog2(NumReq)-1:0] owner_o,
    output logic                      timeout_o
);
    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    ipm_arb_state_e  state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    ipm_op_e         op_q, op_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [31:0]     res_q, res_d;
    logic            err_q, err_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] gnt_idx;
    logic            any_req;

    ipm_rr_arbiter #(
        .NumReq   (NumReq),
        .FixedPrio(FixedPrio)
    ) u_arb (
        .req_i    (req_valid_i),
        .ptr_i    (ptr_q),
        .gnt_idx_o(gnt_idx),
        .any_o    (any_req)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            op_q    <= IPM_OP_MUL;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        timeout_o   = 1'b0;
        case (state_q)
            IDLE: begin
                // The winner is always a valid requester, so ready implies handshake.
                if (any_req) begin
                    req_ready_o[gnt_idx] = 1'b1;
                    owner_d = gnt_idx;
                    op_d    = req_op_i[gnt_idx];
                    a_d     = req_a_i[gnt_idx];
                    b_d     = req_b_i[gnt_idx];
                    res_d   = '0;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = '0;
                if (ipm_valid_i) begin
                    res_d   = ipm_result_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A result arriving on the expiry cycle still counts as a success.
                if (ipm_valid_i) begin
                    res_d   = ipm_result_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CntLast) begin
                    res_d     = '0;
                    err_d     = 1'b1;
                    timeout_o = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                rsp_valid_o[owner_q] = 1'b1;
                if (rsp_ready_i[owner_q]) begin
                    ptr_d   = IdxW'(wrap_inc(int'(owner_q), NumReq));
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ipm_en_o        = (state_q == ISSUE);
    assign ipm_sel_o       = (state_q == ISSUE) || (state_q == WAIT);
    assign busy_o          = (state_q != IDLE);
    assign owner_o         = owner_q;
    assign ipm_operator_o  = op_q;
    assign ipm_operand_a_o = a_q;
    assign ipm_operand_b_o = b_q;
    assign rsp_result_o    = res_q;
    assign rsp_err_o       = err_q;

endmodule

// File: tb/tb_ipm_req_arbiter.sv
// Randomized scoreboard bench: one arbiter per priority mode, each with its own
// requesters, IPM unit model and response monitor.
module tb_ipm_req_arbiter;
    import ipm_req_arbiter_pkg::*;

    localparam int N      = 2;
    localparam int T      = 8;
    localparam int CYCLES = 3000;
    localparam int OW     = $clog2(N);

    typedef struct {
        int          owner;
        logic [31:0] res;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Requester that should win: lowest index (fixed) or first valid at/after ptr.
    function automatic int pick(input logic [N-1:0] v, input int ptr, input bit fp);
        int s, w;
        logic [N-1:0] t;
        s = fp ? 0 : ptr;
        w = -1;
        for (int i = N - 1; i >= 0; i--) begin
            t = v >> ((s + i) % N);
            if (t[0]) w = (s + i) % N;
        end
        return w;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : h
        logic                 rst;
        logic [N-1:0]         req_valid, req_ready, rsp_valid, rsp_ready;
        ipm_op_e [N-1:0]      req_op;
        logic [N-1:0][31:0]   req_a, req_b;
        logic [31:0]          rsp_result, ipm_a, ipm_b, ipm_result;
        logic                 rsp_err, ipm_en, ipm_sel, ipm_valid, busy, tmo;
        ipm_op_e              ipm_op;
        logic [OW-1:0]        owner;
        exp_t                 q[$];
        int                   nresp = 0;
        bit                   fin = 1'b0;

        ipm_req_arbiter #(
            .NumReq       (N),
            .TimeoutCycles(T),
            .FixedPrio    (g == 1)
        ) dut (
            .clk_i          (clk),
            .rst_i          (rst),
            .req_valid_i    (req_valid),
            .req_ready_o    (req_ready),
            .req_op_i       (req_op),
            .req_a_i        (req_a),
            .req_b_i        (req_b),
            .rsp_valid_o    (rsp_valid),
            .rsp_ready_i    (rsp_ready),
            .rsp_result_o   (rsp_result),
            .rsp_err_o      (rsp_err),
            .ipm_en_o       (ipm_en),
            .ipm_sel_o      (ipm_sel),
            .ipm_operator_o (ipm_op),
            .ipm_operand_a_o(ipm_a),
            .ipm_operand_b_o(ipm_b),
            .ipm_valid_i    (ipm_valid),
            .ipm_result_i   (ipm_result),
            .busy_o         (busy),
            .owner_o        (owner),
            .timeout_o      (tmo)
        );

        function automatic string nm(input string s);
            return $sformatf("u%0d.%s", g, s);
        endfunction

        task automatic chk_zero(input string s);
            chk(nm({s, ".ctl"}), {req_ready, rsp_valid, rsp_err, ipm_en, ipm_sel, ipm_op, busy, owner, tmo}, '0);
            chk(nm({s, ".res"}), rsp_result, 0);
            chk(nm({s, ".opa"}), ipm_a, 0);
            chk(nm({s, ".opb"}), ipm_b, 0);
        endtask

        // Stimulus + reference model: arbitration, unit latency, expected responses.
        initial begin
            bit pending = 0, active = 0, hs = 0, do_rst = 0, did_rst = 0;
            int ptr = 0, k = 0, lat = 0, own = 0, w = 0, rst_ph = 0, wd = 0;
            logic [31:0] ures = '0, ca = '0, cb = '0;
            ipm_op_e cop = IPM_OP_MUL;
            logic [N-1:0] exp_rdy, drop;

            rst = 1'b1;
            req_valid = '0;
            for (int r = 0; r < N; r++) req_op[r] = IPM_OP_MUL;
            req_a = '0;
            req_b = '0;
            rsp_ready = '0;
            ipm_valid = 1'b0;
            ipm_result = '0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk_zero("reset");
            @(posedge clk);
            #1 rst = 1'b0;

            for (int cyc = 0; cyc < CYCLES; cyc++) begin
                @(negedge clk);
                drop = '0;
                do_rst = 1'b0;
                if (rst_ph == 1) begin
                    rst_ph = 2;
                end else if (rst_ph == 2) begin
                    chk_zero("midrst");
                    rst_ph = 3;
                end else begin
                    w = pick(req_valid, ptr, g == 1);
                    exp_rdy = (!pending && w >= 0) ? (N'(1) << w) : '0;
                    chk(nm("req_ready"), req_ready, exp_rdy);
                    chk(nm("busy"), busy, pending);
                    chk(nm("ipm_en"), ipm_en, active && k == 0);
                    chk(nm("ipm_sel"), ipm_sel, active);
                    chk(nm("timeout"), tmo, active && k == T && lat > T);
                    if (pending) chk(nm("owner"), owner, own);
                    if (active) begin
                        chk(nm("op"), ipm_op, cop);
                        chk(nm("operands"), {ipm_a, ipm_b}, {ca, cb});
                    end

                    if (active) begin
                        if ((k == lat && lat <= T) || k == T) active = 1'b0;
                        else k++;
                    end else if (pending) begin
                        hs = ((rsp_ready >> own) & N'(1)) != '0;
                        if (hs) begin
                            pending = 1'b0;
                            ptr = (own + 1) % N;
                            wd = 0;
                        end
                    end else if (w >= 0) begin
                        pending = 1'b1;
                        active = 1'b1;
                        k = 0;
                        own = w;
                        for (int r = 0; r < N; r++) begin
                            if (r == w) begin
                                cop = req_op[r];
                                ca = req_a[r];
                                cb = req_b[r];
                            end
                        end
                        case ($urandom_range(0, 5))
                            0: lat = 0;
                            1: lat = 3;
                            2: lat = T;
                            3: lat = T + 1;
                            default: lat = $urandom_range(1, T - 1);
                        endcase
                        ures = $urandom;
                        q.push_back('{own, (lat <= T) ? ures : 32'h0, lat > T});
                        drop = exp_rdy;
                    end

                    if (pending) begin
                        wd++;
                        if (wd == 200) chk(nm("stuck_cycles"), wd, 0);
                    end
                    if (!did_rst && cyc > CYCLES / 2 && active && k >= 1) do_rst = 1'b1;
                end

                @(posedge clk);
                #1;
                if (rst_ph == 3) begin
                    rst = 1'b0;
                    rst_ph = 0;
                end
                if (do_rst) begin
                    rst = 1'b1;
                    rst_ph = 1;
                    did_rst = 1'b1;
                    pending = 1'b0;
                    active = 1'b0;
                    void'(q.pop_back());
                    ptr = 0;
                    wd = 0;
                    req_valid = '0;
                end
                for (int r = 0; r < N; r++) begin
                    if (rst_ph == 0) begin
                        if (drop[r]) req_valid[r] = 1'b0;
                        if (!req_valid[r] && $urandom_range(0, 9) < 7) begin
                            req_valid[r] = 1'b1;
                            req_op[r] = ipm_op_e'(2'($urandom_range(0, 3)));
                            req_a[r] = $urandom;
                            req_b[r] = $urandom;
                        end
                    end
                    rsp_ready[r] = ($urandom_range(0, 9) < 6);
                end
                if (active && k == lat && lat <= T) begin
                    ipm_valid = 1'b1;
                    ipm_result = ures;
                end else if (active) begin
                    ipm_valid = 1'b0;
                    ipm_result = $urandom;
                end else begin
                    // Stray valids while not issued must be ignored by the DUT.
                    ipm_valid = ($urandom_range(0, 3) == 0);
                    ipm_result = $urandom;
                end
            end
            chk(nm("progress"), nresp >= 20, 1);
            chk(nm("did_rst"), did_rst, 1);
            fin = 1'b1;
        end

        // Response monitor: compares whatever the DUT presents against the queue head.
        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                if (rst !== 1'b0 || rsp_valid == '0) continue;
                if (q.size() == 0) begin
                    chk(nm("rsp_unexpected"), rsp_valid, 0);
                    continue;
                end
                e = q[0];
                chk(nm("rsp_valid"), rsp_valid, N'(1) << e.owner);
                chk(nm("rsp_result"), rsp_result, e.res);
                chk(nm("rsp_err"), rsp_err, e.err);
                if (((rsp_ready >> e.owner) & N'(1)) != '0) begin
                    void'(q.pop_front());
                    nresp++;
                end
            end
        end
    end

    initial begin
        wait (h[0].fin && h[1].fin);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
